// File: rtl/block_mover_if.sv
// block_mover_if: bundles the playfield-array <-> block_mover signals.
//   Requests (array -> mover): gen_flag, tick, btn_left, btn_right, btn_rot, piece_sel.
//   Occupancy (array -> mover): arr0..arr11, bit c of arrR = cell (row R, column c).
//   Piece state (mover -> array): x1..x4 (rows), y1..y4 (columns), bottom_flag,
//   top_flag, active, piece_type.
// master = array side, slave = block_mover side.
interface block_mover_if;
  logic       gen_flag;
  logic       tick;
  logic       btn_left;
  logic       btn_right;
  logic       btn_rot;
  logic [2:0] piece_sel;
  logic [9:0] arr0, arr1, arr2, arr3, arr4, arr5, arr6, arr7, arr8, arr9, arr10, arr11;
  logic [3:0] x1, y1, x2, y2, x3, y3, x4, y4;
  logic       bottom_flag;
  logic       top_flag;
  logic       active;
  logic [2:0] piece_type;

  modport master (
    output gen_flag, tick, btn_left, btn_right, btn_rot, piece_sel,
    output arr0, arr1, arr2, arr3, arr4, arr5, arr6, arr7, arr8, arr9, arr10, arr11,
    input  x1, y1, x2, y2, x3, y3, x4, y4,
    input  bottom_flag, top_flag, active, piece_type
  );

  modport slave (
    input  gen_flag, tick, btn_left, btn_right, btn_rot, piece_sel,
    input  arr0, arr1, arr2, arr3, arr4, arr5, arr6, arr7, arr8, arr9, arr10, arr11,
    output x1, y1, x2, y2, x3, y3, x4, y4,
    output bottom_flag, top_flag, active, piece_type
  );
endinterface

// File: rtl/block_mover.sv
// block_mover: owns the single falling tetromino. Spawns on gen_flag, applies
// gravity/left/right/rotate against the occupancy rows, and pulses bottom_flag
// (lock) or top_flag (spawn collision) for one cycle.
// Ports:
//   Clk   - system clock
//   Reset - synchronous active-high reset
//   bus   - block_mover_if.slave (requests, occupancy, cell coordinates, flags)
module block_mover #(
  parameter int SPAWN_ROW = 10,
  parameter int SPAWN_COL = 4
) (
  input logic          Clk,
  input logic          Reset,
  block_mover_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StSpawnChk, StActive, StLock, StTopout} state_e;

  // 3-bit signed offset codes for the shape table
  localparam logic [2:0] M1 = 3'b111;
  localparam logic [2:0] Z0 = 3'b000;
  localparam logic [2:0] P1 = 3'b001;
  localparam logic [2:0] P2 = 3'b010;

  state_e          state_q;
  // Cell coordinates kept as 5-bit two's complement; index 0 is cell 1.
  logic [3:0][4:0] row_q, col_q;
  logic            bottom_q, top_q, active_q;
  logic [2:0]      ptype_q;

  logic [9:0]      occ [12];
  logic [2:0]      sel_m;
  logic [23:0]     shape;
  logic [3:0][4:0] spawn_row, spawn_col;
  logic [3:0][4:0] cand_row, cand_col;
  logic            move_req;
  logic            cand_ok;

  assign occ[0]  = bus.arr0;
  assign occ[1]  = bus.arr1;
  assign occ[2]  = bus.arr2;
  assign occ[3]  = bus.arr3;
  assign occ[4]  = bus.arr4;
  assign occ[5]  = bus.arr5;
  assign occ[6]  = bus.arr6;
  assign occ[7]  = bus.arr7;
  assign occ[8]  = bus.arr8;
  assign occ[9]  = bus.arr9;
  assign occ[10] = bus.arr10;
  assign occ[11] = bus.arr11;

  assign sel_m = (bus.piece_sel == 3'd7) ? 3'd0 : bus.piece_sel;

  // Spawn placement: {dr1,dc1,dr2,dc2,dr3,dc3,dr4,dc4} added to the anchor.
  always_comb begin
    shape = '0;
    unique case (sel_m)
      3'd0:    shape = {Z0, M1, Z0, Z0, Z0, P1, Z0, P2};
      3'd1:    shape = {Z0, P1, Z0, Z0, P1, Z0, P1, P1};
      3'd2:    shape = {Z0, M1, Z0, Z0, Z0, P1, P1, Z0};
      3'd3:    shape = {Z0, M1, Z0, Z0, P1, Z0, P1, P1};
      3'd4:    shape = {P1, M1, Z0, Z0, P1, Z0, Z0, P1};
      3'd5:    shape = {P1, M1, Z0, Z0, Z0, M1, Z0, P1};
      3'd6:    shape = {P1, P1, Z0, Z0, Z0, M1, Z0, P1};
      default: shape = '0;
    endcase
    for (int i = 0; i < 4; i++) begin
      spawn_row[i] = 5'(SPAWN_ROW) + {{2{shape[23-6*i]}}, shape[23-6*i -: 3]};
      spawn_col[i] = 5'(SPAWN_COL) + {{2{shape[20-6*i]}}, shape[20-6*i -: 3]};
    end
  end

  // One candidate per cycle: current cells in SPAWN_CHK, the winning action in ACTIVE.
  always_comb begin
    cand_row = row_q;
    cand_col = col_q;
    move_req = 1'b0;
    if (state_q == StActive) begin
      if (bus.tick) begin
        for (int i = 0; i < 4; i++) cand_row[i] = row_q[i] - 5'd1;
      end else if (bus.btn_rot && ptype_q != 3'd1) begin
        move_req = 1'b1;
        // Clockwise about cell 2: (dr,dc) -> (-dc,dr)
        for (int i = 0; i < 4; i++) begin
          cand_row[i] = row_q[1] - (col_q[i] - col_q[1]);
          cand_col[i] = col_q[1] + (row_q[i] - row_q[1]);
        end
      end else if (bus.btn_left) begin
        move_req = 1'b1;
        for (int i = 0; i < 4; i++) cand_col[i] = col_q[i] - 5'd1;
      end else if (bus.btn_right) begin
        move_req = 1'b1;
        for (int i = 0; i < 4; i++) cand_col[i] = col_q[i] + 5'd1;
      end
    end
  end

  always_comb begin
    cand_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if ($signed(cand_row[i]) < 5'sd0 || $signed(cand_row[i]) > 5'sd11 ||
          $signed(cand_col[i]) < 5'sd0 || $signed(cand_col[i]) > 5'sd9) begin
        cand_ok = 1'b0;
      end else if (occ[cand_row[i][3:0]][cand_col[i][3:0]]) begin
        cand_ok = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      row_q    <= '0;
      col_q    <= '0;
      bottom_q <= 1'b0;
      top_q    <= 1'b0;
      active_q <= 1'b0;
      ptype_q  <= 3'd0;
    end else begin
      bottom_q <= 1'b0;
      top_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.gen_flag) begin
            ptype_q <= sel_m;
            row_q   <= spawn_row;
            col_q   <= spawn_col;
            state_q <= StSpawnChk;
          end
        end
        StSpawnChk: begin
          if (cand_ok) begin
            active_q <= 1'b1;
            state_q  <= StActive;
          end else begin
            top_q   <= 1'b1;
            state_q <= StTopout;
          end
        end
        StActive: begin
          if (bus.tick) begin
            if (cand_ok) begin
              row_q <= cand_row;
            end else begin
              bottom_q <= 1'b1;
              active_q <= 1'b0;
              state_q  <= StLock;
            end
          end else if (move_req && cand_ok) begin
            row_q <= cand_row;
            col_q <= cand_col;
          end
        end
        StLock:   state_q <= StIdle;
        StTopout: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign bus.x1          = row_q[0][3:0];
  assign bus.y1          = col_q[0][3:0];
  assign bus.x2          = row_q[1][3:0];
  assign bus.y2          = col_q[1][3:0];
  assign bus.x3          = row_q[2][3:0];
  assign bus.y3          = col_q[2][3:0];
  assign bus.x4          = row_q[3][3:0];
  assign bus.y4          = col_q[3][3:0];
  assign bus.bottom_flag = bottom_q;
  assign bus.top_flag    = top_q;
  assign bus.active      = active_q;
  assign bus.piece_type  = ptype_q;

endmodule

// File: tb/tb_block_mover.sv
// tb_block_mover: directed self-checking bench for block_mover. Cells are packed as
// {x1,y1,x2,y2,x3,y3,x4,y4}, one hex nibble each, for compact expected values.
module tb_block_mover;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  block_mover_if bif ();

  block_mover #(.SPAWN_ROW(10), .SPAWN_COL(4)) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] cells();
    return {bif.x1, bif.y1, bif.x2, bif.y2, bif.x3, bif.y3, bif.x4, bif.y4};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_arr();
    {bif.arr0, bif.arr1, bif.arr2, bif.arr3, bif.arr4, bif.arr5} = '0;
    {bif.arr6, bif.arr7, bif.arr8, bif.arr9, bif.arr10, bif.arr11} = '0;
  endtask

  // One-cycle action pulse: t=tick, r=rot, l=left, rr=right
  task automatic act(input logic t, input logic r, input logic l, input logic rr);
    bif.tick = t;
    bif.btn_rot = r;
    bif.btn_left = l;
    bif.btn_right = rr;
    step();
    bif.tick = 1'b0;
    bif.btn_rot = 1'b0;
    bif.btn_left = 1'b0;
    bif.btn_right = 1'b0;
  endtask

  // Leaves the bench one cycle after gen_flag (SPAWN_CHK registered)
  task automatic gen(input logic [2:0] sel);
    bif.gen_flag = 1'b1;
    bif.piece_sel = sel;
    step();
    bif.gen_flag = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bif.gen_flag = 1'b0;
    bif.tick = 1'b0;
    bif.btn_left = 1'b0;
    bif.btn_right = 1'b0;
    bif.btn_rot = 1'b0;
    bif.piece_sel = 3'd0;
    clear_arr();
    step();
    step();
    check("reset_cells", cells(), 32'h0);
    check("reset_flags", {29'd0, bif.bottom_flag, bif.top_flag, bif.active}, 32'd0);
    check("reset_type", {29'd0, bif.piece_type}, 32'd0);
    rst = 1'b0;
    step();

    // T spawn into an empty board
    gen(3'd2);
    check("spawn_chk_cells", cells(), 32'hA3A4A5B4);
    check("spawn_chk_active", {31'd0, bif.active}, 32'd0);
    step();
    check("spawn_active", {31'd0, bif.active}, 32'd1);
    check("spawn_cells", cells(), 32'hA3A4A5B4);
    check("spawn_type", {29'd0, bif.piece_type}, 32'd2);

    // gen_flag while active is ignored
    gen(3'd0);
    check("gen_ignored_cells", cells(), 32'hA3A4A5B4);
    check("gen_ignored_type", {29'd0, bif.piece_type}, 32'd2);

    // Fall to anchor row 6, then arr5[4] blocks the next tick
    for (int i = 0; i < 4; i++) act(1'b1, 1'b0, 1'b0, 1'b0);
    check("t_row6", cells(), 32'h63646574);
    bif.arr5 = 10'b00_0001_0000;
    act(1'b1, 1'b0, 1'b0, 1'b0);
    check("occ_lock_bottom", {29'd0, bif.bottom_flag, bif.top_flag, bif.active}, 32'b100);
    check("occ_lock_cells", cells(), 32'h63646574);
    step();
    check("occ_lock_after", {29'd0, bif.bottom_flag, bif.top_flag, bif.active}, 32'd0);
    check("idle_hold_cells", cells(), 32'h63646574);
    clear_arr();

    // T rotation at anchor (5,4), then tick beats left
    gen(3'd2);
    step();
    for (int i = 0; i < 5; i++) act(1'b1, 1'b0, 1'b0, 1'b0);
    check("t_row5", cells(), 32'h53545564);
    act(1'b0, 1'b1, 1'b0, 1'b0);
    check("t_rot", cells(), 32'h64544455);
    act(1'b1, 1'b0, 1'b1, 1'b0);
    check("tick_over_left", cells(), 32'h54443445);

    // Reset mid-piece
    rst = 1'b1;
    step();
    check("midreset_cells", cells(), 32'h0);
    check("midreset_flags", {29'd0, bif.bottom_flag, bif.top_flag, bif.active}, 32'd0);
    check("midreset_type", {29'd0, bif.piece_type}, 32'd0);
    rst = 1'b0;
    step();
    check("midreset_noflag", {29'd0, bif.bottom_flag, bif.top_flag, bif.active}, 32'd0);

    // O ignores rotation
    gen(3'd1);
    step();
    check("o_spawn", cells(), 32'hA5A4B4B5);
    act(1'b0, 1'b1, 1'b0, 1'b0);
    check("o_rot", cells(), 32'hA5A4B4B5);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // I via piece_sel 7: left wall, rotation at column 0, right shift
    gen(3'd7);
    step();
    check("i7_type", {29'd0, bif.piece_type}, 32'd0);
    check("i7_spawn", cells(), 32'hA3A4A5A6);
    for (int i = 0; i < 3; i++) act(1'b0, 1'b0, 1'b1, 1'b0);
    check("i_left3", cells(), 32'hA0A1A2A3);
    act(1'b0, 1'b0, 1'b1, 1'b0);
    check("i_left_wall", cells(), 32'hA0A1A2A3);
    act(1'b0, 1'b1, 1'b0, 1'b0);
    check("i_rot_vert", cells(), 32'hB1A19181);
    act(1'b0, 1'b1, 1'b0, 1'b0);
    check("i_rot_blocked", cells(), 32'hB1A19181);
    act(1'b0, 1'b0, 1'b0, 1'b1);
    check("i_right", cells(), 32'hB2A29282);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // I gravity to the floor
    gen(3'd0);
    step();
    for (int i = 0; i < 10; i++) act(1'b1, 1'b0, 1'b0, 1'b0);
    check("i_floor", cells(), 32'h03040506);
    check("i_floor_active", {31'd0, bif.active}, 32'd1);
    act(1'b1, 1'b0, 1'b0, 1'b0);
    check("floor_lock_flags", {29'd0, bif.bottom_flag, bif.top_flag, bif.active}, 32'b100);
    check("floor_lock_cells", cells(), 32'h03040506);
    step();
    check("floor_after", {29'd0, bif.bottom_flag, bif.top_flag, bif.active}, 32'd0);

    // Top-out
    bif.arr10 = 10'b00_0001_0000;
    gen(3'd2);
    check("topout_chk", {29'd0, bif.bottom_flag, bif.top_flag, bif.active}, 32'd0);
    step();
    check("topout_flag", {29'd0, bif.bottom_flag, bif.top_flag, bif.active}, 32'b010);
    step();
    check("topout_after", {29'd0, bif.bottom_flag, bif.top_flag, bif.active}, 32'd0);
    clear_arr();
    gen(3'd3);
    step();
    check("respawn_active", {31'd0, bif.active}, 32'd1);
    check("respawn_s_cells", cells(), 32'hA3A4B4B5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/block_mover.md
# block_mover

Upstream stage of the playfield array that owns the single falling tetromino. It spawns a piece on the array's generate pulse and applies gravity, left, right and rotate requests against the occupancy rows. It drives the four cell coordinates, signals lock (`bottom_flag`) or spawn collision (`top_flag`) for one cycle, and the array then commits or ends the game.

## Interface
- Parameters:
  - `SPAWN_ROW`, default 10: anchor row at spawn.
  - `SPAWN_COL`, default 4: anchor column at spawn.
- Ports:
  - `Clk`  in  1  system clock; single clock domain.
  - `Reset`  in  1  synchronous, active-high reset.
  - `gen_flag`  in  1  spawn request from the array; honoured only in IDLE.
  - `tick`  in  1  one-cycle gravity pulse.
  - `btn_left`, `btn_right`, `btn_rot`  in  1 each  one-cycle, debounced move pulses.
  - `piece_sel`  in  3  piece type sampled with `gen_flag`; value 7 maps to 0.
  - `arr0`..`arr11`  in  10 each  occupancy; `arrR[c]`=1 means cell (row R, column c) is filled; row 0 is the bottom.
  - `x1,y1`..`x4,y4`  out  4 each  row (x) and column (y) of cells 1..4.
  - `bottom_flag`  out  1  one-cycle lock pulse.
  - `top_flag`  out  1  one-cycle spawn-collision pulse.
  - `active`  out  1  high while a piece is falling.
  - `piece_type`  out  3  type of the current piece.

## Operation
- States: IDLE, SPAWN_CHK, ACTIVE, LOCK, TOPOUT.
- Shapes are (row, column) offsets from the anchor; cell 2 is always (0,0), listed as cells 1..4:
  - 0 I: (0,-1)(0,0)(0,1)(0,2)
  - 1 O: (0,1)(0,0)(1,0)(1,1)
  - 2 T: (0,-1)(0,0)(0,1)(1,0)
  - 3 S: (0,-1)(0,0)(1,0)(1,1)
  - 4 Z: (1,-1)(0,0)(1,0)(0,1)
  - 5 J: (1,-1)(0,0)(0,-1)(0,1)
  - 6 L: (1,1)(0,0)(0,-1)(0,1)
- Rotation is clockwise about cell 2: (dr,dc) → (−dc,dr). Type O ignores `btn_rot`.
- Legality: a candidate placement is legal iff every cell has row 0..11, column 0..9 and an unoccupied array bit.
  - Evaluate with at least 5-bit signed arithmetic; negative or out-of-range values are illegal, never wrapped.
- IDLE:
  - On `gen_flag`, load `piece_type`, zero the rotation offsets and place the anchor at (`SPAWN_ROW`,`SPAWN_COL`).
  - Next state SPAWN_CHK.
- SPAWN_CHK:
  - Spawn placement legal → ACTIVE.
  - Otherwise → TOPOUT, which pulses `top_flag` and returns to IDLE.
- ACTIVE: at most one action per cycle. Priority is `tick` > `btn_rot` > `btn_left` > `btn_right`; lower-priority pulses in the same cycle are dropped.
  - Left/right shift the column by ∓1/+1.
  - Rotate applies the rotation formula.
  - Tick moves the piece down one row. If the move is illegal, go to LOCK without moving.
  - Any illegal action other than tick leaves the coordinates unchanged.
- LOCK: pulses `bottom_flag`, holds the coordinates, then returns to IDLE.
- In IDLE the coordinates hold the last piece's values until the next spawn.
- `active` is 1 only in ACTIVE.
- `gen_flag` outside IDLE is ignored.

## Timing
- Reset values: state IDLE, all `x*`/`y*` = 0, `bottom_flag` = 0, `top_flag` = 0, `active` = 0, `piece_type` = 0, rotation = identity.
- Reset mid-piece aborts the piece with no flag pulse.
- Spawn latency:
  - `gen_flag` high in cycle N → spawn coordinates registered at edge N+1 (SPAWN_CHK).
  - At edge N+2: `active` = 1, or `top_flag` = 1 for exactly one cycle.
- Move latency: an action sampled in cycle N is visible on the coordinates after edge N+1.
- Lock timing:
  - Failing tick in cycle N → `bottom_flag` = 1 during cycle N+1 with the final coordinates stable.
  - `active` is 0 from edge N+1 onward.
- Flags are registered, never high together, and never high for more than one cycle.
- Occupancy is sampled combinationally in the same cycle as the action.

## Test plan
- Spawn into an empty board:
  - `piece_sel`=2 with `gen_flag` → two cycles later, cells (10,3)(10,4)(10,5)(11,4) and `active`=1.
- Gravity to the floor:
  - I piece, 10 ticks → anchor row 0.
  - 11th tick → `bottom_flag` pulses once with cells (0,3)(0,4)(0,5)(0,6), then `active`=0.
- Wall and occupancy blocking:
  - I piece, 3× `btn_left` → columns 0..3; a 4th press leaves them unchanged.
  - `arr5[4]`=1 stops a T piece falling at anchor row 6.
- Rotation:
  - T at anchor (5,4) plus `btn_rot` → cells (6,4)(5,4)(4,4)(5,5).
  - O plus `btn_rot` → unchanged.
  - I piece at column 0 rotating to (−1..2) legal rows only.
- Simultaneous events:
  - `tick` and `btn_left` in the same cycle → row −1 only, column unchanged.
  - `gen_flag` while ACTIVE → ignored.
- Top-out and reset:
  - `arr10[4]`=1 plus spawn → `top_flag` for one cycle, `active` stays 0.
  - `Reset` during ACTIVE → all outputs 0 after the next edge, no flag.
